sipo_deserializer: RTL

Serial-in/parallel-out deserializer that sits directly downstream of the `d_flip_flop` data path. It consumes the registered serial bit stream (`q`) one qualified bit per clock, packs `WIDTH` bits into a word, and presents that word on a valid/ready output port. It also flags words lost to back-pressure.

---
 rtl/sipo_deserializer.sv | 88 ++++++++
 1 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: packs WIDTH qualified serial bits into a
// word and holds it on a valid/ready port, flagging words lost to back-pressure.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             word_done;
    logic             accept;

    always_comb begin
        sr_next = sr;
        if (MSB_FIRST)
            sr_next = {sr[WIDTH-2:0], din};
        else
            sr_next = {din, sr[WIDTH-1:1]};
    end

    // A bit arriving with clear is discarded, so it can never complete a word.
    assign word_done  = din_valid && !clear && (bit_cnt == LAST);
    assign accept     = (state == FULL) && dout_ready;
    assign dout_valid = (state == FULL);

    // NOTE: asynchronous active-low reset sits in the sensitivity list so state
    // clears the moment rst falls, not at the next clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            sr      <= '0;
            bit_cnt <= '0;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every branch below see the
            // pre-edge values, so word_done and accept are evaluated consistently.
            if (clear) begin
                sr      <= '0;
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (din_valid) begin
                sr      <= sr_next;
                bit_cnt <= (bit_cnt >= LAST) ? '0 : bit_cnt + CW'(1);
            end

            case (state)
                EMPTY: begin
                    if (word_done) begin
                        dout  <= sr_next;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (word_done && accept) begin
                        dout <= sr_next;
                    end else if (word_done) begin
                        overrun <= 1'b1;
                    end else if (accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
